// File: rtl/packet_pkg.sv
// packet_pkg: shared FSM state, header geometry and byte-enable helpers for the packet parser/builder pair
package packet_pkg;
  typedef enum logic [1:0] {IDLE, HDR, BODY, TAIL} state_t;
  function automatic int hdr_words(input int d, input int a, input int b);
    return (a + b) / d;
  endfunction
  function automatic int carry_bytes(input int d, input int a, input int b);
    return (a + b) % d;
  endfunction
  function automatic int cnt_width(input int hw);
    return $clog2(hw + 1);
  endfunction
  function automatic int byteen_count(input logic [63:0] be);
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) n += int'(be[i]);
    return n;
  endfunction
  function automatic logic [63:0] count_to_byteen(input int k, input int d);
    return ((64'd1 << k) - 64'd1) << (d - k);
  endfunction
endpackage

// File: rtl/packet_builder_out_reg.sv
// packet_builder_out_reg: registered output beat that loads when the slot is free and holds while stalled
module packet_builder_out_reg #(
  parameter int D = 8
) (
  input  logic           clk_host,
  input  logic           rst,
  input  logic           load,
  input  logic           ld_sop,
  input  logic           ld_eop,
  input  logic [D-1:0]   ld_byteen,
  input  logic [8*D-1:0] ld_data,
  input  logic           ready,
  output logic           free,
  output logic           valid,
  output logic           sop,
  output logic           eop,
  output logic [D-1:0]   byteen,
  output logic [8*D-1:0] data
);
  assign free = !valid || ready;
  always_ff @(posedge clk_host) begin
    if (rst) begin
      valid <= 1'b0;
      sop <= 1'b0;
      eop <= 1'b0;
      byteen <= '0;
      data <= '0;
    end else if (free) begin
      valid <= load;
      if (load) begin
        sop <= ld_sop;
        eop <= ld_eop;
        byteen <= ld_byteen;
        data <= ld_data;
      end
    end
  end
endmodule

// File: rtl/packet_builder.sv
// packet_builder: prepends big-endian headers A and B to a payload stream and realigns the payload behind them
// Define PACKET_BUILDER_STATS_EN to add the pkt_count output (count of emitted packets).
module packet_builder
  import packet_pkg::*;
#(
  parameter int WIDTH_DATA_BYTES  = 8,
  parameter int WIDTH_HDR_A_BYTES = 6,
  parameter int WIDTH_HDR_B_BYTES = 4
) (
  input  logic                           clk_host,
  input  logic                           rst,
  input  logic                           bus_in_valid,
  output logic                           bus_in_ready,
  input  logic                           bus_in_sop,
  input  logic                           bus_in_eop,
  input  logic [WIDTH_DATA_BYTES-1:0]    bus_in_byteen,
  input  logic [8*WIDTH_DATA_BYTES-1:0]  bus_in_data,
  input  logic [8*WIDTH_HDR_A_BYTES-1:0] headerA,
  input  logic [8*WIDTH_HDR_B_BYTES-1:0] headerB,
  output logic                           bus_out_valid,
  input  logic                           bus_out_ready,
  output logic                           bus_out_sop,
  output logic                           bus_out_eop,
  output logic [WIDTH_DATA_BYTES-1:0]    bus_out_byteen,
  output logic [8*WIDTH_DATA_BYTES-1:0]  bus_out_data
`ifdef PACKET_BUILDER_STATS_EN
  ,
  output logic [15:0]                    pkt_count
`endif
);
  localparam int D = WIDTH_DATA_BYTES;
  localparam int H = WIDTH_HDR_A_BYTES + WIDTH_HDR_B_BYTES;
  localparam int HW = hdr_words(D, WIDTH_HDR_A_BYTES, WIDTH_HDR_B_BYTES);
  localparam int S = carry_bytes(D, WIDTH_HDR_A_BYTES, WIDTH_HDR_B_BYTES);
  localparam int CW = cnt_width(HW);
  localparam int HB = 8 * D * HW;
  if (HW < 1 || S < 1 || S > D - 1) begin : g_bad_cfg
    $error("packet_builder: header must span at least one full word and leave 1..D-1 carry bytes");
  end
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [HB-1:0] hdr;
  logic [8*H-1:0] hdr_in;
  logic [8*S-1:0] carry;
  logic [S-1:0] carry_be;
  logic free, load, ld_sop, ld_eop, take, short_eop;
  logic [D-1:0] ld_byteen;
  logic [8*D-1:0] ld_data;
  assign hdr_in = {headerA, headerB};
  assign bus_in_ready = state == BODY && free;
  assign take = bus_in_valid && bus_in_ready;
  assign short_eop = byteen_count(64'(bus_in_byteen)) <= D - S;
  always_comb begin
    state_n = state;
    load = 1'b0;
    ld_sop = 1'b0;
    ld_eop = 1'b0;
    ld_byteen = '1;
    ld_data = hdr[HB-1 -: 8*D];
    case (state)
      IDLE: if (bus_in_valid && bus_in_sop && free) begin
        load = 1'b1;
        ld_sop = 1'b1;
        ld_data = hdr_in[8*H-1 -: 8*D];
        state_n = HW > 1 ? HDR : BODY;
      end
      HDR: if (free) begin
        load = 1'b1;
        state_n = cnt == CW'(HW - 1) ? BODY : HDR;
      end
      BODY: if (take) begin
        load = 1'b1;
        ld_data = {carry, bus_in_data[8*D-1 -: 8*(D-S)]};
        ld_byteen = {{S{1'b1}}, bus_in_byteen[D-1 -: D-S]};
        ld_eop = bus_in_eop && short_eop;
        state_n = !bus_in_eop ? BODY : short_eop ? IDLE : TAIL;
      end
      default: if (free) begin
        load = 1'b1;
        ld_data = {carry, {8*(D-S){1'b0}}};
        ld_byteen = {carry_be, {(D-S){1'b0}}};
        ld_eop = 1'b1;
        state_n = IDLE;
      end
    endcase
  end
  // hdr is a shift register: the next full header word to emit always sits at the top
  always_ff @(posedge clk_host) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      hdr <= '0;
      carry <= '0;
      carry_be <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && load) begin
        hdr <= hdr_in[8*H-1 -: HB] << (8*D);
        cnt <= CW'(HW > 1);
        carry <= hdr_in[8*S-1:0];
        carry_be <= '1;
      end
      if (state == HDR && load) begin
        hdr <= hdr << (8*D);
        cnt <= state_n == BODY ? '0 : cnt + 1'b1;
      end
      if (take) begin
        carry <= bus_in_data[8*S-1:0];
        carry_be <= bus_in_byteen[S-1:0];
      end
    end
  end
  packet_builder_out_reg #(.D(D)) u_out (
    .clk_host (clk_host),
    .rst      (rst),
    .load     (load),
    .ld_sop   (ld_sop),
    .ld_eop   (ld_eop),
    .ld_byteen(ld_byteen),
    .ld_data  (ld_data),
    .ready    (bus_out_ready),
    .free     (free),
    .valid    (bus_out_valid),
    .sop      (bus_out_sop),
    .eop      (bus_out_eop),
    .byteen   (bus_out_byteen),
    .data     (bus_out_data)
  );
`ifdef PACKET_BUILDER_STATS_EN
  always_ff @(posedge clk_host) begin
    if (rst) pkt_count <= '0;
    else if (bus_out_valid && bus_out_ready && bus_out_eop) pkt_count <= pkt_count + 1'b1;
  end
`endif
endmodule

// File: doc/packet_builder.md
Name: packet_builder

Overview:
Transmit-side counterpart of the header-stripping parser. It takes a realigned payload stream plus header A and header B field values, prepends the headers in big-endian byte order, and re-aligns the payload behind them. The output is a 64-bit aligned packet stream in the same valid/sop/eop/byteen format.
Both sides use valid/ready handshakes because the output packet is longer than the input packet.

Parameters:
WIDTH_DATA_BYTES, 8, bus width in bytes (D)
WIDTH_HDR_A_BYTES, 6, header A length in bytes (A)
WIDTH_HDR_B_BYTES, 4, header B length in bytes (B)

Ports:
clk_host  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
bus_in_valid  in  1  payload beat valid
bus_in_ready  out  1  payload beat accepted when valid && ready
bus_in_sop  in  1  first payload beat
bus_in_eop  in  1  last payload beat
bus_in_byteen  in  D  byte enables; thermometer from MSB; all-ones except on eop beat
bus_in_data  in  8*D  payload; byte 0 at MSB
headerA  in  8*A  header A value; sampled on the sop beat
headerB  in  8*B  header B value; sampled on the sop beat
bus_out_valid  out  1  output beat valid (registered)
bus_out_ready  in  1  downstream accepts beat
bus_out_sop  out  1  first output beat
bus_out_eop  out  1  last output beat
bus_out_byteen  out  D  output byte enables
bus_out_data  out  8*D  output data

Behaviour:
- Derived values:
  - H = A+B
  - HW = H/D (full header words)
  - S = H%D (carry bytes)
  - Defaults give HW=1, S=2.
- Elaboration $error unless HW>=1 and 1<=S<=D-1.
- Reset: state IDLE; all outputs (bus_out_*, bus_in_ready) 0; carry/header registers 0. Reset mid-packet drops the packet silently. No partial eop is emitted.
- Output slot free: free = !bus_out_valid || bus_out_ready.
- Stall rule: while bus_out_valid && !bus_out_ready, every bus_out_* signal holds stable.
- bus_in_ready = (state==BODY) && free. It is combinational and 0 in all other states.
- Header sampling: headerA/headerB must be stable while bus_in_valid && bus_in_sop is presented in IDLE. The sop beat is NOT consumed in IDLE.
- IDLE:
  - Trigger: bus_in_valid && bus_in_sop && free.
  - Capture the H-byte concatenation {headerA, headerB} into the header register.
  - Drive header word 0 with byteen all-ones and sop=1.
  - If HW>1, go to HDR; else go to BODY with carry = low S bytes of the header.
- HDR:
  - On each free cycle, emit the next full header word (byteen all-ones, sop=0) and advance the word counter.
  - After word HW-1, go to BODY with carry = low S bytes of the header.
- BODY, on each input handshake:
  - Output data = {carry, upper D-S bytes of bus_in_data}.
  - Output byteen = {S ones, upper D-S bits of bus_in_byteen}.
  - carry <= low S bytes of bus_in_data; carry_be <= low S bits of bus_in_byteen.
- BODY, on the eop beat, with k = popcount(bus_in_byteen):
  - If k <= D-S: emit with eop=1, go to IDLE.
  - Else: emit with eop=0, go to TAIL.
- TAIL:
  - When free, emit {carry, zeros} with byteen = {carry_be, zeros} (k-(D-S) ones) and eop=1.
  - Go to IDLE.
- Latency: first output beat is valid 1 cycle after the sop beat is presented in IDLE (with free).
- Overhead per packet: HW header beats, plus 1 TAIL beat when k > D-S.
- Back-to-back packets: IDLE accepts a new sop in the cycle after the eop/TAIL beat is registered. There is no additional bubble.
- Input protocol errors (sop in BODY, bus_in_valid with sop=0 in IDLE) are ignored:
  - In IDLE, non-sop beats are not accepted (ready=0). Upstream stalls; the bench must not generate this.
- Wrap-around: no counters exceed HW-1; the header word counter is $clog2(HW+1) bits wide.

Optional Feature:
- Macro: PACKET_BUILDER_STATS_EN.
- When defined:
  - Adds output port pkt_count (16 bits).
  - Increments on every output handshake with bus_out_eop=1; wraps 16'hFFFF -> 0.
  - Resets to 0.
- When undefined: the port and counter do not exist. Functional behaviour is otherwise identical.

Decomposition:
- Shared package packet_pkg holds:
  - state enum (IDLE, HDR, BODY, TAIL)
  - localparam functions for HW, S, and the header counter width
  - function byteen_count (thermometer -> count) and function count_to_byteen (count -> thermometer)
- The parser reuses the same package.
- One sub-module, packet_builder_out_reg:
  - Output register stage with load/hold under the free/stall rule.
  - Holds valid/sop/eop/byteen/data.

Test Plan:
- Short single-beat packet:
  - Stimulus: headerA=48'hA0A1A2A3A4A5, headerB=32'hB0B1B2B3, data=64'h0001020300000000, byteen=8'hF0.
  - Expect: A0A1A2A3A4A5B0B1/FF sop; then B2B3000102030000/FC eop.
- Full-width single-beat packet:
  - Stimulus: data=64'h0001020304050607, byteen=FF.
  - Expect three beats: header word/FF sop; B2B3000102030405/FF; 0607000000000000/C0 eop (TAIL path).
- 3-beat packet, last byteen=8'hE0:
  - Expect 4 output beats; last byteen=8'hF8, eop; mid beats FF.
  - Carry bytes are correct across beats.
- Backpressure:
  - Stimulus: bus_out_ready pattern 1,0,0,1,0,1 during test 3.
  - Expect: identical output sequence; outputs stable while stalled; bus_in_ready=0 whenever the slot is not free.
- Back-to-back packets: two 2-beat packets (last byteen FF, then 80) with sop presented immediately after eop.
  - First packet: 4 output beats (its last beat goes through TAIL).
  - Second packet: 3 output beats, last byteen E0.
  - No idle cycle between the first packet's last beat and the second packet's header beat.
- Reset mid-packet:
  - Stimulus: assert rst for 1 cycle during BODY of packet 1.
  - Expect: all outputs 0 next cycle, no eop emitted; a fresh packet then builds correctly.
  - With PACKET_BUILDER_STATS_EN: pkt_count=0 after reset, 1 after the fresh packet.
